fc_w_rd_chunked: RTL and testbench

- Weight-fetch front end for the Fc datapath and the successor of the single-descriptor Fc weight reader.
- Splits an arbitrarily long weight stream into DMA descriptors of at most MAX_CHUNK_BYTES. Supports a descriptor ready handshake and checks tlast against chunk boundaries.
- Converts each AXIS beat into LANES zero-point-corrected 9-bit weights and pushes them into the Fc weight FIFO under prog_full backpressure.

---
 rtl/fc_w_rd_chunked.sv | 141 ++++++++++++++
 tb/tb_fc_w_rd_chunked.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_w_rd_chunked.sv
// fc_w_rd_chunked: chunked DMA weight fetch feeding zero-point-corrected 9-bit lanes into the Fc weight FIFO
module fc_w_rd_chunked #(
    parameter int AXIS_DW         = 512,
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 20,
    parameter int MAX_CHUNK_BYTES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_pulse,
    output logic                     done_pulse,
    output logic                     busy,
    input  logic [7:0]               wz,
    input  logic [31:0]              w_addr,
    input  logic [31:0]              w_n_bytes,
    output logic [ADDR_W-1:0]        dma_rd_desc_addr,
    output logic [LEN_W-1:0]         dma_rd_desc_len,
    output logic                     dma_rd_desc_valid,
    input  logic                     dma_rd_desc_ready,
    input  logic [AXIS_DW-1:0]       dma_rd_read_data_tdata,
    input  logic                     dma_rd_read_data_tvalid,
    output logic                     dma_rd_read_data_tready,
    input  logic                     dma_rd_read_data_tlast,
    output logic                     w_fifo_wr_en,
    output logic [AXIS_DW/8*9-1:0]   w_fifo_din,
    input  logic                     w_fifo_prog_full,
    output logic                     err_tlast
);
    localparam int LANES     = AXIS_DW / 8;
    localparam int MAX_BEATS = MAX_CHUNK_BYTES / LANES;

    typedef enum logic {D_IDLE, D_ISSUE} desc_st_e;
    typedef enum logic {R_IDLE, R_RUN} data_st_e;

    desc_st_e           dst_q, dst_d;
    data_st_e           dat_q, dat_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               v_q, v_d, last_q, last_d;
    logic [7:0]         wz_q, wz_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        rem_desc_q, rem_desc_d, rem_beats_q, rem_beats_d, chunk_q, chunk_d;
    logic [AXIS_DW-1:0] data_q, data_d;
    logic [31:0]        chunk_bytes, start_beats, left_beats;
    logic               start_acc, beat;

    assign start_acc   = start_pulse && !busy_q;
    assign beat        = dma_rd_read_data_tvalid && dma_rd_read_data_tready;
    assign chunk_bytes = (rem_desc_q < 32'(MAX_CHUNK_BYTES)) ? rem_desc_q : 32'(MAX_CHUNK_BYTES);
    assign start_beats = w_n_bytes / 32'(LANES);
    assign left_beats  = rem_beats_q - 32'd1;

    assign done_pulse              = done_q;
    assign busy                    = busy_q;
    assign err_tlast               = err_q;
    assign w_fifo_wr_en            = v_q;
    assign dma_rd_desc_valid       = dst_q == D_ISSUE;
    assign dma_rd_desc_addr        = addr_q;
    assign dma_rd_desc_len         = LEN_W'(chunk_bytes);
    assign dma_rd_read_data_tready = (dat_q == R_RUN) && !w_fifo_prog_full;

    // Next-state for both FSMs, the chunk/total beat counters and the single-beat output stage
    always_comb begin
        dst_d       = dst_q;
        dat_d       = dat_q;
        busy_d      = done_q ? 1'b0 : busy_q;
        done_d      = v_q && last_q;
        err_d       = err_q;
        wz_d        = wz_q;
        addr_d      = addr_q;
        rem_desc_d  = rem_desc_q;
        rem_beats_d = rem_beats_q;
        chunk_d     = chunk_q;
        v_d         = beat;
        data_d      = beat ? dma_rd_read_data_tdata : data_q;
        last_d      = beat && rem_beats_q == 32'd1;
        if (dst_q == D_ISSUE && dma_rd_desc_ready) begin
            addr_d     = addr_q + ADDR_W'(chunk_bytes);
            rem_desc_d = rem_desc_q - chunk_bytes;
            dst_d      = (rem_desc_q == chunk_bytes) ? D_IDLE : D_ISSUE;
        end
        if (beat) begin
            err_d       = err_q || (dma_rd_read_data_tlast != (chunk_q == 32'd1));
            rem_beats_d = left_beats;
            chunk_d     = (chunk_q != 32'd1) ? chunk_q - 32'd1 :
                          (left_beats < 32'(MAX_BEATS)) ? left_beats : 32'(MAX_BEATS);
            dat_d       = (rem_beats_q == 32'd1) ? R_IDLE : R_RUN;
        end
        if (start_acc) begin
            busy_d      = 1'b1;
            done_d      = w_n_bytes == 32'd0;
            err_d       = 1'b0;
            wz_d        = wz;
            addr_d      = ADDR_W'(w_addr);
            rem_desc_d  = w_n_bytes;
            rem_beats_d = start_beats;
            chunk_d     = (start_beats < 32'(MAX_BEATS)) ? start_beats : 32'(MAX_BEATS);
            dst_d       = (w_n_bytes == 32'd0) ? D_IDLE : D_ISSUE;
            dat_d       = (w_n_bytes == 32'd0) ? R_IDLE : R_RUN;
        end
    end

    // Lane-wise zero-point subtraction on the registered beat
    always_comb begin
        w_fifo_din = '0;
        for (int i = 0; i < LANES; i++)
            w_fifo_din[9*i +: 9] = {1'b0, data_q[8*i +: 8]} - {1'b0, wz_q};
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q       <= D_IDLE;
            dat_q       <= R_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wz_q        <= '0;
            addr_q      <= '0;
            rem_desc_q  <= '0;
            rem_beats_q <= '0;
            chunk_q     <= '0;
            v_q         <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            dst_q       <= dst_d;
            dat_q       <= dat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wz_q        <= wz_d;
            addr_q      <= addr_d;
            rem_desc_q  <= rem_desc_d;
            rem_beats_q <= rem_beats_d;
            chunk_q     <= chunk_d;
            v_q         <= v_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end
endmodule

// File: tb/tb_fc_w_rd_chunked.sv
// tb_fc_w_rd_chunked: randomized self-checking bench for fc_w_rd_chunked against a transaction-level model
module tb_fc_w_rd_chunked;
    localparam int AXIS_DW = 512, ADDR_W = 32, LEN_W = 20, MAXC = 4096;
    localparam int LANES = AXIS_DW / 8, DW = LANES * 9, CW = 640;

    logic clk = 0, rst = 1, start_pulse = 0, done_pulse, busy;
    logic [7:0] wz = 0;
    logic [31:0] w_addr = 0, w_n_bytes = 0;
    logic [ADDR_W-1:0] desc_addr;
    logic [LEN_W-1:0] desc_len;
    logic desc_valid, desc_ready = 0;
    logic [AXIS_DW-1:0] tdata = 0;
    logic tvalid = 0, tready, tlast = 0, wr_en, pf = 0, err_tlast;
    logic [DW-1:0] din;

    always #5 clk = ~clk;

    fc_w_rd_chunked #(.AXIS_DW(AXIS_DW), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CHUNK_BYTES(MAXC)) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .done_pulse(done_pulse), .busy(busy),
        .wz(wz), .w_addr(w_addr), .w_n_bytes(w_n_bytes),
        .dma_rd_desc_addr(desc_addr), .dma_rd_desc_len(desc_len),
        .dma_rd_desc_valid(desc_valid), .dma_rd_desc_ready(desc_ready),
        .dma_rd_read_data_tdata(tdata), .dma_rd_read_data_tvalid(tvalid),
        .dma_rd_read_data_tready(tready), .dma_rd_read_data_tlast(tlast),
        .w_fifo_wr_en(wr_en), .w_fifo_din(din), .w_fifo_prog_full(pf), .err_tlast(err_tlast)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // reference model state
    logic [DW-1:0] exp_q[$];
    logic [ADDR_W-1:0] ea_q[$];
    logic [LEN_W-1:0] el_q[$];
    logic [DW-1:0] e_in, e_out;
    logic [ADDR_W-1:0] prev_a, ma, pa;
    logic [LEN_W-1:0] prev_l, pl;
    logic [7:0] m_wz;
    bit busy_m, done_m, acc_prev, data_act, err_m, prev_stall, rst_prev, fin;
    bit nx_busy, nx_done, nx_acc, nx_act, nx_err;
    int tot, acc_n, wr_n, ml;
    longint mr;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (rst_prev)
                chk("rst_out", {done_pulse, busy, desc_valid, desc_addr, desc_len, tready, wr_en, din, err_tlast}, '0);
            busy_m = 0; done_m = 0; acc_prev = 0; data_act = 0; err_m = 0; prev_stall = 0;
            exp_q.delete(); ea_q.delete(); el_q.delete();
        end else begin
            chk("busy", busy, busy_m);
            if (done_pulse || done_m) chk("done", done_pulse, done_m);
            chk("err", err_tlast, err_m);
            chk("tready", tready, data_act && !pf);
            if (wr_en || acc_prev) chk("wr_en", wr_en, acc_prev);
            if (acc_prev && exp_q.size() != 0) begin
                e_out = exp_q.pop_front();
                if (wr_en) chk("din", din, e_out);
            end
            if (prev_stall) chk("desc_hold", {desc_valid, desc_addr, desc_len}, {1'b1, prev_a, prev_l});
            if (desc_valid && desc_ready) begin
                chk("desc_present", ea_q.size() != 0, 1);
                if (ea_q.size() != 0) begin
                    pa = ea_q.pop_front();
                    pl = el_q.pop_front();
                    chk("desc", {desc_addr, desc_len}, {pa, pl});
                end
            end
            prev_stall = desc_valid && !desc_ready;
            prev_a = desc_addr;
            prev_l = desc_len;
            nx_busy = done_m ? 1'b0 : busy_m;
            nx_done = 0; nx_err = err_m; nx_act = data_act; nx_acc = 0;
            if (acc_prev) begin
                wr_n++;
                if (wr_n == tot) nx_done = 1;
            end
            if (data_act && tvalid && !pf) begin
                for (int i = 0; i < LANES; i++) e_in[9*i +: 9] = 9'(int'(tdata[8*i +: 8]) - int'(m_wz));
                exp_q.push_back(e_in);
                acc_n++;
                if (tlast != (((acc_n * LANES) % MAXC == 0) || acc_n == tot)) nx_err = 1;
                if (acc_n == tot) nx_act = 0;
                nx_acc = 1;
            end
            if (start_pulse && !busy_m) begin
                nx_busy = 1; m_wz = wz; tot = int'(w_n_bytes) / LANES; acc_n = 0; wr_n = 0;
                nx_act = tot != 0; nx_done = tot == 0; nx_err = 0;
                ea_q.delete(); el_q.delete(); exp_q.delete();
                ma = w_addr; mr = longint'(w_n_bytes);
                while (mr > 0) begin
                    ml = (mr < MAXC) ? int'(mr) : MAXC;
                    ea_q.push_back(ma); el_q.push_back(LEN_W'(ml));
                    ma += ADDR_W'(ml); mr -= ml;
                end
            end
            busy_m = nx_busy; done_m = nx_done; err_m = nx_err; data_act = nx_act; acc_prev = nx_acc;
        end
        rst_prev = rst;
    end

    function automatic logic [AXIS_DW-1:0] gen(input int fill);
        logic [AXIS_DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[8*i +: 8] = (fill < 0) ? 8'($urandom) : 8'(fill);
        return d;
    endfunction

    task automatic src(input int nb, input int fill, input int inj);
        int k = 1, t = 0;
        bit take = 1;
        while (k <= nb && t < 6000) begin
            @(posedge clk); #1; t++;
            if (take) begin
                tvalid = $urandom_range(3) != 0;
                tdata = gen(fill);
                tlast = (((k * LANES) % MAXC == 0) || k == nb) ^ (k == inj);
            end
            @(negedge clk);
            take = !tvalid || tready;
            if (tvalid && tready) k++;
        end
        @(posedge clk); #1;
        tvalid = 0; tlast = 0;
        chk("src_done", k > nb, 1);
    endtask

    task automatic drv(input int pf_start, input int pf_len, input int rdy_low, input bit rnd, input bit spur);
        int c = 0;
        while (!fin) begin
            @(posedge clk); #1; c++;
            desc_ready = (c < rdy_low) ? 1'b0 : (rnd ? 1'($urandom_range(1)) : 1'b1);
            pf = (pf_len > 0 && c >= pf_start && c < pf_start + pf_len) ? 1'b1 : (rnd && $urandom_range(7) == 0);
            start_pulse = spur && c == 20;
            if (spur && c == 20) w_n_bytes = 32'd64;
        end
    endtask

    task automatic run(input int n, input logic [31:0] addr, input logic [7:0] z, input int fill, input int inj,
                       input int pf_start, input int pf_len, input int rdy_low, input bit rnd, input bit spur);
        int t = 0;
        fin = 0;
        desc_ready = rdy_low == 0;
        @(posedge clk); #1;
        w_n_bytes = n; w_addr = addr; wz = z; start_pulse = 1;
        @(posedge clk); #1;
        start_pulse = 0;
        fork
            src(n / LANES, fill, inj);
            drv(pf_start, pf_len, rdy_low, rnd, spur);
        join_none
        while (!done_pulse && t < 8000) begin @(negedge clk); t++; end
        chk("done_seen", done_pulse, 1);
        repeat (2) @(negedge clk);
        fin = 1;
        wait fork;
        pf = 0; desc_ready = 0; start_pulse = 0;
        @(negedge clk);
        chk("desc_left", ea_q.size(), 0);
        chk("beats_left", exp_q.size(), 0);
        chk("idle", {busy, desc_valid, tready}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        run(128, 32'h1000, 8'h80, 8'h85, 0, 0, 0, 0, 0, 0);
        run(9984, 32'h0, 8'($urandom), -1, 0, 0, 0, 0, 0, 1);
        run(8704, 32'h4000_0000, 8'($urandom), -1, 0, 0, 0, 5, 0, 0);
        run(2560, 32'h2_0000, 8'hFF, 0, 0, 10, 10, 0, 0, 0);
        run(4096, 32'h8000, 8'($urandom), -1, 10, 0, 0, 0, 0, 0);
        chk("err_sticky", err_tlast, 1);
        @(posedge clk); #1;
        w_n_bytes = 8192; w_addr = 32'h9000; wz = 8'h33; start_pulse = 1;
        @(posedge clk); #1;
        start_pulse = 0; tvalid = 1; tdata = gen(-1); tlast = 0; desc_ready = 1;
        repeat (6) @(posedge clk);
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0; tvalid = 0; desc_ready = 0;
        run(0, 32'h100, 8'h11, -1, 0, 0, 0, 0, 0, 0);
        chk("err_after_rst", err_tlast, 0);
        for (int i = 0; i < 4; i++)
            run(LANES * $urandom_range(0, 150), $urandom & ~32'h3F, 8'($urandom), -1,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0, 0, 0, 0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
